// File: rtl/ioctl_upload_ctrl.sv
// HPS upload controller: borrows the shared memory port from the game core and
// serves byte reads to the HPS with a wait-stall handshake and running checksum.
module ioctl_upload_ctrl #(
    parameter int unsigned AW    = 10,
    parameter int unsigned DEPTH = 1024
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          ioctl_upload,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic          PAUSE_REQ,
    input  logic          PAUSE_ACK,
    output logic          MEM_SEL,
    output logic [AW-1:0] MEM_ADDR,
    input  logic [7:0]    MEM_DATA,
    output logic          DONE,
    output logic [7:0]    CHECKSUM
);

    localparam int unsigned HPS_AW = 25;
    localparam logic [HPS_AW-1:0] DEPTH_A = HPS_AW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_READY,
        S_FETCH,
        S_LATCH
    } state_t;

    state_t        state_q, state_d;
    logic          upl_q, upl_d;
    logic [7:0]    din_q, din_d;
    logic          wait_q, wait_d;
    logic          pause_q, pause_d;
    logic          sel_q, sel_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          done_q, done_d;
    logic [7:0]    cks_q, cks_d;

    // Next-state and registered-output logic; a dropped upload overrides everything.
    always_comb begin
        state_d = state_q;
        upl_d   = ioctl_upload;
        din_d   = din_q;
        wait_d  = wait_q;
        pause_d = pause_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        cks_d   = cks_q;

        if (state_q != S_IDLE && !ioctl_upload) begin
            state_d = S_IDLE;
            pause_d = 1'b0;
            sel_d   = 1'b0;
            wait_d  = 1'b0;
            done_d  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ioctl_upload && !upl_q) begin
                        state_d = S_HOLD;
                        pause_d = 1'b1;
                        wait_d  = 1'b1;
                        cks_d   = 8'h00;
                    end
                end
                S_HOLD: begin
                    if (PAUSE_ACK) begin
                        state_d = S_READY;
                        sel_d   = 1'b1;
                        wait_d  = 1'b0;
                    end
                end
                S_READY: begin
                    if (ioctl_rd) begin
                        if (ioctl_addr < DEPTH_A) begin
                            addr_d  = AW'(ioctl_addr);
                            wait_d  = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            din_d = 8'hFF;
                        end
                    end
                end
                S_FETCH: state_d = S_LATCH;
                S_LATCH: begin
                    din_d   = MEM_DATA;
                    cks_d   = cks_q + MEM_DATA;
                    wait_d  = 1'b0;
                    state_d = S_READY;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            upl_q   <= 1'b0;
            din_q   <= 8'h00;
            wait_q  <= 1'b0;
            pause_q <= 1'b0;
            sel_q   <= 1'b0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            cks_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            upl_q   <= upl_d;
            din_q   <= din_d;
            wait_q  <= wait_d;
            pause_q <= pause_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            cks_q   <= cks_d;
        end
    end

    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign PAUSE_REQ  = pause_q;
    assign MEM_SEL    = sel_q;
    assign MEM_ADDR   = addr_q;
    assign DONE       = done_q;
    assign CHECKSUM   = cks_q;

endmodule
